bus_cycle_ctrl: RTL and testbench

- Downstream of the instruction decode/timing unit: converts machine-cycle requests (opcode fetch, memory/IO read or write, INTA) into 8085 bus pin activity.
- Pins driven: ALE, RDn, WRn, IOMn, S0, S1, the multiplexed AD7-0 and A15-8, plus the HOLD/HLDA handshake.
- Returns read data and a cycle-done pulse to the decoder; inserts wait states from READY.
- One T-state = one phi1 cycle.

---
 rtl/bus_pkg.sv | 60 ++++++
 rtl/bus_cycle_ctrl_if.sv | 43 ++++
 rtl/bus_wait_timer.sv | 25 ++
 rtl/bus_cycle_ctrl.sv | 153 +++++++++++++++
 tb/tb_bus_cycle_ctrl.sv | 346 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/bus_pkg.sv
// Shared types and constants for the 8085 bus cycle controller and the
// instruction decode/timing unit that feeds it.
package bus_pkg;

    // Machine-cycle request kinds issued by the decoder.
    typedef enum logic [2:0] {
        CYC_OPF  = 3'd0,
        CYC_MRD  = 3'd1,
        CYC_MWR  = 3'd2,
        CYC_IORD = 3'd3,
        CYC_IOWR = 3'd4,
        CYC_INTA = 3'd5,
        CYC_HALT = 3'd6
    } cyc_t;

    // Bus controller T-states.
    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_T1   = 3'd1,
        ST_T2   = 3'd2,
        ST_TW   = 3'd3,
        ST_T3   = 3'd4,
        ST_HOLD = 3'd5
    } state_t;

    // Status encodings, packed as {s1, s0, io_m_n}.
    localparam logic [2:0] STAT_OPF  = 3'b110;
    localparam logic [2:0] STAT_MRD  = 3'b100;
    localparam logic [2:0] STAT_MWR  = 3'b010;
    localparam logic [2:0] STAT_IORD = 3'b101;
    localparam logic [2:0] STAT_IOWR = 3'b011;
    localparam logic [2:0] STAT_INTA = 3'b111;
    localparam logic [2:0] STAT_HALT = 3'b000;

    // One-hot T-state flags, used by the decoder for its own sequencing.
    localparam logic [5:0] TOH_IDLE = 6'b000001;
    localparam logic [5:0] TOH_T1   = 6'b000010;
    localparam logic [5:0] TOH_T2   = 6'b000100;
    localparam logic [5:0] TOH_TW   = 6'b001000;
    localparam logic [5:0] TOH_T3   = 6'b010000;
    localparam logic [5:0] TOH_HOLD = 6'b100000;

    function automatic logic [2:0] status_of(cyc_t t);
        case (t)
            CYC_OPF:  return STAT_OPF;
            CYC_MRD:  return STAT_MRD;
            CYC_MWR:  return STAT_MWR;
            CYC_IORD: return STAT_IORD;
            CYC_IOWR: return STAT_IOWR;
            CYC_INTA: return STAT_INTA;
            default:  return STAT_HALT;
        endcase
    endfunction

    // Cycles that pull RDn and sample AD7-0 in T3.
    function automatic logic is_read(cyc_t t);
        return (t == CYC_OPF) || (t == CYC_MRD) || (t == CYC_IORD) || (t == CYC_INTA);
    endfunction

endpackage

// File: rtl/bus_cycle_ctrl_if.sv
// Request/response and pin bundle between the decoder, the bus cycle
// controller and the 8085 pads. The controller uses the slave modport.
interface bus_cycle_ctrl_if;
    import bus_pkg::*;

    logic        cyc_start;
    cyc_t        cyc_type;
    logic [15:0] addr;
    logic [7:0]  wdata;
    logic        ready;
    logic        hold;
    logic [7:0]  ad_in;

    logic        cyc_ready;
    logic        cyc_done;
    logic [7:0]  rdata;
    logic        rdata_valid;
    logic        ale;
    logic        rd_n;
    logic        wr_n;
    logic        io_m_n;
    logic        s1;
    logic        s0;
    logic [7:0]  ad_out;
    logic        ad_oe;
    logic [7:0]  a_hi;
    logic        bus_oe;
    logic        hlda;
    logic        timeout;

    modport slave (
        input  cyc_start, cyc_type, addr, wdata, ready, hold, ad_in,
        output cyc_ready, cyc_done, rdata, rdata_valid, ale, rd_n, wr_n,
               io_m_n, s1, s0, ad_out, ad_oe, a_hi, bus_oe, hlda, timeout
    );

    modport master (
        output cyc_start, cyc_type, addr, wdata, ready, hold, ad_in,
        input  cyc_ready, cyc_done, rdata, rdata_valid, ale, rd_n, wr_n,
               io_m_n, s1, s0, ad_out, ad_oe, a_hi, bus_oe, hlda, timeout
    );

endinterface

// File: rtl/bus_wait_timer.sv
// Wait-state counter for the bus cycle controller: cleared on T2 entry,
// bumped on every entry into TW, flags when the count reaches MAX_WAIT.
module bus_wait_timer #(
    parameter int unsigned MAX_WAIT = 255
) (
    input  logic phi1,
    input  logic reset,
    input  logic clear,
    input  logic inc,
    output logic at_max
);

    logic [7:0] count;

    // Count TW states of the current cycle.
    always_ff @(posedge phi1) begin
        if (reset || clear)
            count <= 8'd0;
        else if (inc)
            count <= count + 8'd1;
    end

    assign at_max = (count == MAX_WAIT[7:0]);

endmodule

// File: rtl/bus_cycle_ctrl.sv
// 8085 bus cycle controller: turns decoder machine-cycle requests into
// ALE/RDn/WRn/status/AD pin activity, inserts READY wait states and
// services HOLD/HLDA. Optional wait-state timeout under BUS_TIMEOUT_EN.
module bus_cycle_ctrl
    import bus_pkg::*;
#(
    parameter int unsigned MAX_WAIT = 255
) (
    input  logic             phi1,
    input  logic             reset,
    bus_cycle_ctrl_if.slave  bus
);

    state_t     state;
    cyc_t       type_q;
    logic [7:0] wdata_q;
    logic       accept;
    logic       force_t3;
    logic       go_t3;

    // T3 never continues into TW, so only IDLE and T3 can take a request.
    assign bus.cyc_ready = ((state == ST_IDLE) || (state == ST_T3)) && !bus.hold;
    assign accept        = bus.cyc_start && bus.cyc_ready;
    assign go_t3         = bus.ready || force_t3;

`ifdef BUS_TIMEOUT_EN
    logic wt_clear;
    logic wt_inc;
    logic wt_at_max;

    assign wt_clear = (state == ST_T1) && (type_q != CYC_HALT);
    assign wt_inc   = ((state == ST_T2) || (state == ST_TW)) && !go_t3;
    assign force_t3 = (state == ST_TW) && wt_at_max;

    bus_wait_timer #(.MAX_WAIT(MAX_WAIT)) u_wait_timer (
        .phi1   (phi1),
        .reset  (reset),
        .clear  (wt_clear),
        .inc    (wt_inc),
        .at_max (wt_at_max)
    );
`else
    logic unused_max_wait;
    assign unused_max_wait = (MAX_WAIT != 0);
    assign force_t3        = 1'b0;
`endif

    // Write data is only consumed from T2 onward, so it needs no reset.
    always_ff @(posedge phi1) begin
        if (accept)
            wdata_q <= bus.wdata;
    end

    // T-state sequencer with all pin outputs registered.
    always_ff @(posedge phi1) begin
        if (reset) begin
            state           <= ST_IDLE;
            type_q          <= CYC_OPF;
            bus.rd_n        <= 1'b1;
            bus.wr_n        <= 1'b1;
            bus.ale         <= 1'b0;
            bus.ad_oe       <= 1'b0;
            bus.bus_oe      <= 1'b1;
            bus.hlda        <= 1'b0;
            bus.s1          <= 1'b0;
            bus.s0          <= 1'b0;
            bus.io_m_n      <= 1'b0;
            bus.a_hi        <= 8'd0;
            bus.ad_out      <= 8'd0;
            bus.rdata       <= 8'd0;
            bus.cyc_done    <= 1'b0;
            bus.rdata_valid <= 1'b0;
            bus.timeout     <= 1'b0;
        end else begin
            bus.cyc_done    <= 1'b0;
            bus.rdata_valid <= 1'b0;
            bus.timeout     <= 1'b0;
            bus.ale         <= 1'b0;

            case (state)
                ST_IDLE: begin
                    if (bus.hold) begin
                        state      <= ST_HOLD;
                        bus.hlda   <= 1'b1;
                        bus.bus_oe <= 1'b0;
                        bus.ad_oe  <= 1'b0;
                    end
                end
                ST_T1: begin
                    if (type_q == CYC_HALT) begin
                        state     <= ST_IDLE;
                        bus.ad_oe <= 1'b0;
                    end else if (is_read(type_q)) begin
                        state     <= ST_T2;
                        bus.rd_n  <= 1'b0;
                        bus.ad_oe <= 1'b0;
                    end else begin
                        state      <= ST_T2;
                        bus.wr_n   <= 1'b0;
                        bus.ad_oe  <= 1'b1;
                        bus.ad_out <= wdata_q;
                    end
                end
                ST_T2, ST_TW: begin
                    if (go_t3) begin
                        state        <= ST_T3;
                        bus.cyc_done <= 1'b1;
                        bus.timeout  <= force_t3 && !bus.ready;
                    end else begin
                        state <= ST_TW;
                    end
                end
                ST_T3: begin
                    bus.rd_n  <= 1'b1;
                    bus.wr_n  <= 1'b1;
                    bus.ad_oe <= 1'b0;
                    if (is_read(type_q)) begin
                        bus.rdata       <= bus.ad_in;
                        bus.rdata_valid <= 1'b1;
                    end
                    if (bus.hold) begin
                        state      <= ST_HOLD;
                        bus.hlda   <= 1'b1;
                        bus.bus_oe <= 1'b0;
                    end else begin
                        state <= ST_IDLE;
                    end
                end
                ST_HOLD: begin
                    if (!bus.hold) begin
                        state      <= ST_IDLE;
                        bus.hlda   <= 1'b0;
                        bus.bus_oe <= 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase

            // A new request (from IDLE or straight out of T3) starts T1.
            if (accept) begin
                state        <= ST_T1;
                type_q       <= bus.cyc_type;
                {bus.s1, bus.s0, bus.io_m_n} <= status_of(bus.cyc_type);
                bus.ale      <= 1'b1;
                bus.ad_oe    <= 1'b1;
                bus.ad_out   <= bus.addr[7:0];
                bus.a_hi     <= bus.addr[15:8];
                bus.cyc_done <= (bus.cyc_type == CYC_HALT);
            end
        end
    end

endmodule

// File: tb/tb_bus_cycle_ctrl.sv
// Directed testbench for bus_cycle_ctrl. Inputs are driven and outputs
// sampled on the falling edge of phi1. Define BUS_TIMEOUT_EN to also
// exercise the wait-state timeout with MAX_WAIT=4.
module tb_bus_cycle_ctrl;
    import bus_pkg::*;

`ifdef BUS_TIMEOUT_EN
    localparam int unsigned TB_MAX_WAIT = 4;
`else
    localparam int unsigned TB_MAX_WAIT = 255;
`endif

    logic phi1 = 1'b0;
    logic reset;
    int   n_cmp = 0;
    int   n_err = 0;

    bus_cycle_ctrl_if bif ();

    bus_cycle_ctrl #(.MAX_WAIT(TB_MAX_WAIT)) dut (
        .phi1  (phi1),
        .reset (reset),
        .bus   (bif)
    );

    always #5 phi1 = ~phi1;

    wire [2:0] stat = {bif.s1, bif.s0, bif.io_m_n};

    task automatic tick();
        @(negedge phi1);
    endtask

    task automatic test_reset();
        n_cmp++;
        if ({bif.rd_n, bif.wr_n, bif.ale, bif.ad_oe, bif.bus_oe, bif.hlda} !== 6'b110010) begin
            n_err++;
            $display("FAIL reset_ctrl: got %b want 110010",
                     {bif.rd_n, bif.wr_n, bif.ale, bif.ad_oe, bif.bus_oe, bif.hlda});
        end
        n_cmp++;
        if ({stat, bif.a_hi, bif.ad_out, bif.rdata} !== 27'd0) begin
            n_err++;
            $display("FAIL reset_data: got %h want 0", {stat, bif.a_hi, bif.ad_out, bif.rdata});
        end
        n_cmp++;
        if ({bif.cyc_done, bif.rdata_valid, bif.timeout, bif.cyc_ready} !== 4'b0001) begin
            n_err++;
            $display("FAIL reset_pulses: got %b want 0001",
                     {bif.cyc_done, bif.rdata_valid, bif.timeout, bif.cyc_ready});
        end
    endtask

    task automatic test_mrd();
        bif.cyc_start = 1'b1; bif.cyc_type = CYC_MRD; bif.addr = 16'h2050; bif.ready = 1'b1;
        tick();
        bif.cyc_start = 1'b0;
        // T1
        n_cmp++;
        if ({bif.ale, bif.ad_oe, bif.rd_n, bif.cyc_ready, bif.ad_out, bif.a_hi, stat} !== {4'b1110, 8'h50, 8'h20, 3'b100}) begin
            n_err++;
            $display("FAIL mrd_t1: got %h want %h",
                     {bif.ale, bif.ad_oe, bif.rd_n, bif.cyc_ready, bif.ad_out, bif.a_hi, stat},
                     {4'b1110, 8'h50, 8'h20, 3'b100});
        end
        tick();
        bif.ad_in = 8'hA5;
        // T2
        n_cmp++;
        if ({bif.ale, bif.rd_n, bif.wr_n, bif.ad_oe, bif.cyc_done} !== 5'b00100) begin
            n_err++;
            $display("FAIL mrd_t2: got %b want 00100", {bif.ale, bif.rd_n, bif.wr_n, bif.ad_oe, bif.cyc_done});
        end
        tick();
        // T3
        n_cmp++;
        if ({bif.ale, bif.rd_n, bif.cyc_done, bif.cyc_ready, bif.rdata_valid} !== 5'b00110) begin
            n_err++;
            $display("FAIL mrd_t3: got %b want 00110", {bif.ale, bif.rd_n, bif.cyc_done, bif.cyc_ready, bif.rdata_valid});
        end
        tick();
        bif.ad_in = 8'h00;
        // first IDLE cycle: data returned, strobe released, status kept
        n_cmp++;
        if ({bif.rd_n, bif.cyc_done, bif.rdata_valid, bif.rdata, stat} !== {3'b101, 8'hA5, 3'b100}) begin
            n_err++;
            $display("FAIL mrd_rdata: got %h want %h", {bif.rd_n, bif.cyc_done, bif.rdata_valid, bif.rdata, stat},
                     {3'b101, 8'hA5, 3'b100});
        end
        tick();
        n_cmp++;
        if (bif.rdata_valid !== 1'b0) begin
            n_err++;
            $display("FAIL mrd_valid_pulse: got %b want 0", bif.rdata_valid);
        end
    endtask

    task automatic test_iowr_wait();
        int done_cnt = 0;
        bif.cyc_start = 1'b1; bif.cyc_type = CYC_IOWR; bif.addr = 16'h0042;
        bif.wdata = 8'h3C; bif.ready = 1'b0;
        tick();
        bif.cyc_start = 1'b0;
        bif.wdata = 8'hFF;
        // T1
        n_cmp++;
        if ({bif.ad_out, bif.a_hi, stat, bif.wr_n} !== {8'h42, 8'h00, 3'b011, 1'b1}) begin
            n_err++;
            $display("FAIL iowr_t1: got %h want %h", {bif.ad_out, bif.a_hi, stat, bif.wr_n}, {8'h42, 8'h00, 3'b011, 1'b1});
        end
        tick();
        // T2
        n_cmp++;
        if ({bif.wr_n, bif.rd_n, bif.ad_oe, bif.ad_out} !== {3'b011, 8'h3C}) begin
            n_err++;
            $display("FAIL iowr_t2: got %h want %h", {bif.wr_n, bif.rd_n, bif.ad_oe, bif.ad_out}, {3'b011, 8'h3C});
        end
        // three wait states, READY returns during the third
        for (int i = 0; i < 3; i++) begin
            tick();
            done_cnt += int'(bif.cyc_done);
            if (i == 2) bif.ready = 1'b1;
        end
        n_cmp++;
        if ({bif.wr_n, bif.ad_oe, bif.timeout} !== 3'b010) begin
            n_err++;
            $display("FAIL iowr_tw: got %b want 010", {bif.wr_n, bif.ad_oe, bif.timeout});
        end
        tick();
        done_cnt += int'(bif.cyc_done);
        // T3 after exactly three TW
        n_cmp++;
        if ({bif.cyc_done, bif.wr_n, bif.ad_oe, bif.ad_out, stat} !== {3'b101, 8'h3C, 3'b011}) begin
            n_err++;
            $display("FAIL iowr_t3: got %h want %h", {bif.cyc_done, bif.wr_n, bif.ad_oe, bif.ad_out, stat},
                     {3'b101, 8'h3C, 3'b011});
        end
        tick();
        done_cnt += int'(bif.cyc_done);
        n_cmp++;
        if ({bif.wr_n, bif.ad_oe, bif.rdata_valid} !== 3'b100) begin
            n_err++;
            $display("FAIL iowr_end: got %b want 100", {bif.wr_n, bif.ad_oe, bif.rdata_valid});
        end
        n_cmp++;
        if (done_cnt !== 1) begin
            n_err++;
            $display("FAIL iowr_done_count: got %0d want 1", done_cnt);
        end
    endtask

    task automatic test_back_to_back();
        int first_done = -1;
        int second_done = -1;
        bif.cyc_start = 1'b1; bif.cyc_type = CYC_OPF; bif.addr = 16'h1000; bif.ready = 1'b1;
        for (int cyc = 1; cyc <= 8; cyc++) begin
            tick();
            bif.cyc_start = 1'b0;
            if (bif.cyc_done === 1'b1) begin
                if (first_done < 0) first_done = cyc;
                else if (second_done < 0) second_done = cyc;
            end
            if (cyc == 3) begin
                // OPF T3: launch the MRD right here
                n_cmp++;
                if ({bif.cyc_ready, bif.cyc_done, stat} !== 5'b11110) begin
                    n_err++;
                    $display("FAIL b2b_t3_ready: got %b want 11110", {bif.cyc_ready, bif.cyc_done, stat});
                end
                bif.cyc_start = 1'b1; bif.cyc_type = CYC_MRD; bif.addr = 16'h1234;
            end
            if (cyc == 4) begin
                n_cmp++;
                if ({bif.ale, bif.cyc_done, bif.ad_out, bif.a_hi, stat} !== {2'b10, 8'h34, 8'h12, 3'b100}) begin
                    n_err++;
                    $display("FAIL b2b_t1: got %h want %h", {bif.ale, bif.cyc_done, bif.ad_out, bif.a_hi, stat},
                             {2'b10, 8'h34, 8'h12, 3'b100});
                end
            end
        end
        // OPF T3 at cycle 3, MRD T1/T2/T3 at cycles 4..6
        n_cmp++;
        if ((first_done !== 3) || (second_done !== 6)) begin
            n_err++;
            $display("FAIL b2b_done_spacing: got %0d,%0d want 3,6", first_done, second_done);
        end
    endtask

    task automatic test_hold();
        bif.cyc_start = 1'b1; bif.cyc_type = CYC_MRD; bif.addr = 16'h0300; bif.ready = 1'b1;
        tick();
        bif.cyc_start = 1'b0;
        tick();
        bif.hold = 1'b1;
        tick();
        // T3 completes despite the pending hold
        n_cmp++;
        if ({bif.cyc_done, bif.hlda, bif.bus_oe, bif.cyc_ready, bif.rd_n} !== 5'b10100) begin
            n_err++;
            $display("FAIL hold_t3: got %b want 10100", {bif.cyc_done, bif.hlda, bif.bus_oe, bif.cyc_ready, bif.rd_n});
        end
        tick();
        n_cmp++;
        if ({bif.hlda, bif.bus_oe, bif.ad_oe, bif.rd_n, bif.wr_n, bif.cyc_ready} !== 6'b100110) begin
            n_err++;
            $display("FAIL hold_enter: got %b want 100110",
                     {bif.hlda, bif.bus_oe, bif.ad_oe, bif.rd_n, bif.wr_n, bif.cyc_ready});
        end
        bif.cyc_start = 1'b1; bif.cyc_type = CYC_MWR; bif.addr = 16'hBEEF;
        tick();
        n_cmp++;
        if ({bif.hlda, bif.ale, bif.bus_oe} !== 3'b100) begin
            n_err++;
            $display("FAIL hold_ignore_start: got %b want 100", {bif.hlda, bif.ale, bif.bus_oe});
        end
        bif.hold = 1'b0;
        tick();
        bif.cyc_start = 1'b0;
        n_cmp++;
        if ({bif.hlda, bif.bus_oe, bif.ale, bif.a_hi} !== {3'b010, 8'h03}) begin
            n_err++;
            $display("FAIL hold_release: got %h want %h", {bif.hlda, bif.bus_oe, bif.ale, bif.a_hi}, {3'b010, 8'h03});
        end
        tick();
    endtask

    task automatic test_reset_mid_cycle();
        bif.cyc_start = 1'b1; bif.cyc_type = CYC_MRD; bif.addr = 16'h4444; bif.ready = 1'b0;
        tick();
        bif.cyc_start = 1'b0;
        tick();
        tick();
        // in TW
        n_cmp++;
        if ({bif.rd_n, bif.cyc_done, bif.cyc_ready} !== 3'b000) begin
            n_err++;
            $display("FAIL rstmid_tw: got %b want 000", {bif.rd_n, bif.cyc_done, bif.cyc_ready});
        end
        reset = 1'b1;
        bif.ready = 1'b1;
        tick();
        n_cmp++;
        if ({bif.rd_n, bif.ale, bif.cyc_done, bif.cyc_ready, bif.ad_oe} !== 5'b10010) begin
            n_err++;
            $display("FAIL rstmid_abort: got %b want 10010", {bif.rd_n, bif.ale, bif.cyc_done, bif.cyc_ready, bif.ad_oe});
        end
        reset = 1'b0;
        tick();
        n_cmp++;
        if ({bif.cyc_done, bif.rdata_valid, bif.rd_n} !== 3'b001) begin
            n_err++;
            $display("FAIL rstmid_after: got %b want 001", {bif.cyc_done, bif.rdata_valid, bif.rd_n});
        end
    endtask

`ifdef BUS_TIMEOUT_EN
    task automatic test_timeout();
        int tw_seen = 0;
        bif.cyc_start = 1'b1; bif.cyc_type = CYC_MRD; bif.addr = 16'h5000; bif.ready = 1'b0;
        tick();
        bif.cyc_start = 1'b0;
        tick();
        // T2, then count TW until cyc_done shows up
        for (int i = 0; i < 10; i++) begin
            tick();
            if (bif.cyc_done === 1'b1) break;
            tw_seen++;
        end
        n_cmp++;
        if (tw_seen !== 4) begin
            n_err++;
            $display("FAIL timeout_tw_count: got %0d want 4", tw_seen);
        end
        n_cmp++;
        if ({bif.cyc_done, bif.timeout, bif.rd_n} !== 3'b110) begin
            n_err++;
            $display("FAIL timeout_pulse: got %b want 110", {bif.cyc_done, bif.timeout, bif.rd_n});
        end
        tick();
        n_cmp++;
        if ({bif.timeout, bif.rdata_valid} !== 2'b01) begin
            n_err++;
            $display("FAIL timeout_after: got %b want 01", {bif.timeout, bif.rdata_valid});
        end
        bif.ready = 1'b1;
        tick();
    endtask
`else
    task automatic test_no_timeout();
        bif.cyc_start = 1'b1; bif.cyc_type = CYC_IORD; bif.addr = 16'h0077; bif.ready = 1'b0;
        tick();
        bif.cyc_start = 1'b0;
        tick();
        // ten wait states: no forced T3 and no timeout without the option
        for (int i = 0; i < 10; i++) tick();
        n_cmp++;
        if ({bif.cyc_done, bif.timeout, bif.rd_n, stat} !== 6'b000101) begin
            n_err++;
            $display("FAIL long_wait: got %b want 000101", {bif.cyc_done, bif.timeout, bif.rd_n, stat});
        end
        bif.ready = 1'b1;
        tick();
        n_cmp++;
        if ({bif.cyc_done, bif.timeout} !== 2'b10) begin
            n_err++;
            $display("FAIL long_wait_t3: got %b want 10", {bif.cyc_done, bif.timeout});
        end
        tick();
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset         = 1'b1;
        bif.cyc_start = 1'b0;
        bif.cyc_type  = CYC_OPF;
        bif.addr      = 16'h0000;
        bif.wdata     = 8'h00;
        bif.ready     = 1'b1;
        bif.hold      = 1'b0;
        bif.ad_in     = 8'h00;
        tick();
        tick();
        test_reset();
        reset = 1'b0;
        tick();
        test_mrd();
        test_iowr_wait();
        test_back_to_back();
        test_hold();
        test_reset_mid_cycle();
`ifdef BUS_TIMEOUT_EN
        test_timeout();
`else
        test_no_timeout();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
